// File: rtl/axi_default_slave.sv
// Terminating AXI4 slave for unmapped addresses: every burst completes with DECERR,
// write data is discarded, reads return zeros, and a sticky log records the first offender.
module axi_default_slave #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [7:0]          ARLEN,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  input  logic                err_clr,
  output logic                err_valid,
  output logic [ADDR_W-1:0]   err_addr,
  output logic                err_is_write,
  output logic [CNT_W-1:0]    err_count
);

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t        w_state, w_state_next;
  r_state_t        r_state, r_state_next;
  logic [ID_W-1:0] bid_q, rid_q;
  logic [7:0]      rlen_q, rcnt_q;
  logic            aw_hs, ar_hs, r_hs, r_last;
  logic [1:0]      log_inc;
  logic            log_empty;

  // Write data, strobes and burst length are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{AWLEN, WDATA, WSTRB};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign aw_hs  = AWVALID && (w_state == W_IDLE);
  assign ar_hs  = ARVALID && (r_state == R_IDLE);
  assign r_last = (rcnt_q == rlen_q);
  assign r_hs   = RREADY && (r_state == R_DATA);

  always_comb begin
    w_state_next = w_state;
    AWREADY      = 1'b0;
    WREADY       = 1'b0;
    BVALID       = 1'b0;
    BID          = bid_q;
    BRESP        = RESP_DECERR;
    unique case (w_state)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) w_state_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && WLAST) w_state_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next = r_state;
    ARREADY      = 1'b0;
    RVALID       = 1'b0;
    RLAST        = 1'b0;
    RID          = rid_q;
    RDATA        = '0;
    RRESP        = RESP_DECERR;
    unique case (r_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) r_state_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        RLAST  = r_last;
        if (RREADY && r_last) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      bid_q   <= '0;
    end else begin
      w_state <= w_state_next;
      if (aw_hs) bid_q <= AWID;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      rid_q   <= '0;
      rlen_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      r_state <= r_state_next;
      if (ar_hs) begin
        rid_q  <= ARID;
        rlen_q <= ARLEN;
        rcnt_q <= '0;
      end else if (r_hs && !r_last) begin
        rcnt_q <= rcnt_q + 8'd1;
      end
    end
  end

  // Clear takes effect before same-cycle events, so a coinciding handshake lands in a fresh log.
  assign log_inc   = {1'b0, aw_hs} + {1'b0, ar_hs};
  assign log_empty = err_clr || !err_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid    <= 1'b0;
      err_addr     <= '0;
      err_is_write <= 1'b0;
      err_count    <= '0;
    end else begin
      err_count <= sat_add(err_clr ? '0 : err_count, log_inc);
      if (log_empty && aw_hs) begin
        err_valid    <= 1'b1;
        err_addr     <= AWADDR;
        err_is_write <= 1'b1;
      end else if (log_empty && ar_hs) begin
        err_valid    <= 1'b1;
        err_addr     <= ARADDR;
        err_is_write <= 1'b0;
      end else if (err_clr) begin
        err_valid    <= 1'b0;
        err_addr     <= '0;
        err_is_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_default_slave.sv
// Directed bench for axi_default_slave: write/read DECERR bursts, stalls, error log and reset.
module tb_axi_default_slave;

  localparam int ID_W = 8, ADDR_W = 32, DATA_W = 32, CNT_W = 8;

  logic clk, rst;
  logic [ID_W-1:0] AWID, BID, ARID, RID;
  logic [ADDR_W-1:0] AWADDR, ARADDR, err_addr;
  logic [7:0] AWLEN, ARLEN;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DATA_W-1:0] WDATA, RDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic [1:0] BRESP, RRESP;
  logic err_clr, err_valid, err_is_write;
  logic [CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_pass   = 0;

  axi_default_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .err_clr(err_clr), .err_valid(err_valid), .err_addr(err_addr),
    .err_is_write(err_is_write), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  bit [0:4] rr_pat   = 5'b10011;
  bit [0:4] last_pat = 5'b00001;

  initial begin
    int beats;
    rst = 1'b1; err_clr = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
    step(); step();

    // Reset values
    chk("rst_awready", AWREADY, 1);  chk("rst_arready", ARREADY, 1);
    chk("rst_wready", WREADY, 0);    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);    chk("rst_rlast", RLAST, 0);
    chk("rst_bid", BID, 0);          chk("rst_rid", RID, 0);
    chk("rst_rdata", RDATA, 0);      chk("rst_bresp", BRESP, 2'b11);
    chk("rst_rresp", RRESP, 2'b11);  chk("rst_err_valid", err_valid, 0);
    chk("rst_err_addr", err_addr, 0); chk("rst_err_is_write", err_is_write, 0);
    chk("rst_err_count", err_count, 0);
    rst = 1'b0;
    step();

    // Write burst of four beats
    AWVALID = 1'b1; AWID = 8'h12; AWADDR = 32'h3000_0000; AWLEN = 8'd3;
    chk("w1_awready_pre", AWREADY, 1);
    chk("w1_wready_pre", WREADY, 0);
    step();
    AWVALID = 1'b0;
    chk("w1_wready", WREADY, 1);       chk("w1_awready_busy", AWREADY, 0);
    chk("w1_err_valid", err_valid, 1); chk("w1_err_addr", err_addr, 32'h3000_0000);
    chk("w1_err_is_write", err_is_write, 1); chk("w1_err_count", err_count, 1);
    for (int i = 0; i < 4; i++) begin
      WVALID = 1'b1; WDATA = 32'hDEAD_0000 + i; WSTRB = 4'hF; WLAST = (i == 3);
      chk("w1_beat_wready", WREADY, 1);
      chk("w1_beat_bvalid", BVALID, 0);
      step();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk("w1_bvalid", BVALID, 1);  chk("w1_bid", BID, 8'h12);
    chk("w1_bresp", BRESP, 2'b11); chk("w1_wready_off", WREADY, 0);
    step();
    chk("w1_bvalid_hold", BVALID, 1); chk("w1_bid_hold", BID, 8'h12);
    BREADY = 1'b1;
    step();
    chk("w1_awready_back", AWREADY, 1); chk("w1_bvalid_done", BVALID, 0);

    // Read burst of eight beats, no stalls
    ARVALID = 1'b1; ARID = 8'h05; ARADDR = 32'h4000_0000; ARLEN = 8'd7;
    chk("r1_arready_pre", ARREADY, 1);
    step();
    ARVALID = 1'b0; RREADY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("r1_rvalid", RVALID, 1);   chk("r1_rdata", RDATA, 0);
      chk("r1_rresp", RRESP, 2'b11); chk("r1_rid", RID, 8'h05);
      chk("r1_rlast", RLAST, (i == 7)); chk("r1_arready_busy", ARREADY, 0);
      step();
    end
    chk("r1_arready_back", ARREADY, 1); chk("r1_rvalid_done", RVALID, 0);
    chk("r1_err_count", err_count, 2);  chk("r1_err_addr_kept", err_addr, 32'h3000_0000);

    // Read burst of three beats with RREADY stalls
    ARVALID = 1'b1; ARID = 8'h0A; ARADDR = 32'h4000_0100; ARLEN = 8'd2;
    step();
    ARVALID = 1'b0;
    beats = 0;
    for (int i = 0; i < 5; i++) begin
      RREADY = rr_pat[i];
      chk("r2_rvalid", RVALID, 1); chk("r2_rid", RID, 8'h0A);
      chk("r2_rdata", RDATA, 0);   chk("r2_rlast", RLAST, last_pat[i]);
      if (RVALID && RREADY) beats++;
      step();
    end
    chk("r2_beats", beats, 3);
    chk("r2_arready_back", ARREADY, 1); chk("r2_rvalid_done", RVALID, 0);

    // Clear the log, then simultaneous AW and AR on an empty log
    err_clr = 1'b1; RREADY = 1'b0; BREADY = 1'b0;
    step();
    err_clr = 1'b0;
    chk("clr_err_valid", err_valid, 0); chk("clr_err_count", err_count, 0);
    chk("clr_err_addr", err_addr, 0);   chk("clr_err_is_write", err_is_write, 0);
    AWVALID = 1'b1; AWID = 8'h21; AWADDR = 32'h5000_0010;
    ARVALID = 1'b1; ARID = 8'h22; ARADDR = 32'h6000_0020; ARLEN = 8'd1;
    step();
    AWVALID = 1'b0; ARVALID = 1'b0;
    chk("both_err_addr", err_addr, 32'h5000_0010);
    chk("both_err_is_write", err_is_write, 1);
    chk("both_err_count", err_count, 2);
    WVALID = 1'b1; WLAST = 1'b1; RREADY = 1'b1;
    chk("both_wready", WREADY, 1); chk("both_rvalid0", RVALID, 1);
    chk("both_rid", RID, 8'h22);   chk("both_rlast0", RLAST, 0);
    step();
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    chk("both_bvalid", BVALID, 1); chk("both_bid", BID, 8'h21);
    chk("both_rlast1", RLAST, 1);  chk("both_rvalid1", RVALID, 1);
    step();
    chk("both_awready", AWREADY, 1); chk("both_arready", ARREADY, 1);
    chk("both_bvalid_done", BVALID, 0); chk("both_rvalid_done", RVALID, 0);

    // Clear coinciding with an AR handshake, then counter saturation
    err_clr = 1'b1; ARVALID = 1'b1; ARID = 8'h03; ARADDR = 32'h7000_0004; ARLEN = 8'd0;
    step();
    err_clr = 1'b0; ARVALID = 1'b0;
    chk("clrhs_err_valid", err_valid, 1); chk("clrhs_err_addr", err_addr, 32'h7000_0004);
    chk("clrhs_err_is_write", err_is_write, 0); chk("clrhs_err_count", err_count, 1);
    chk("clrhs_rlast", RLAST, 1);
    step();
    ARVALID = 1'b1; ARADDR = 32'h7100_0000;
    for (int i = 0; i < 300; i++) begin
      step(); step();
      if (i == 99) chk("sat_count_101", err_count, 101);
    end
    ARVALID = 1'b0;
    chk("sat_count_255", err_count, 255);
    chk("sat_err_addr_kept", err_addr, 32'h7000_0004);
    chk("sat_arready", ARREADY, 1);

    // Reset during beat 2 of an eight-beat read
    ARVALID = 1'b1; ARID = 8'h33; ARADDR = 32'h7200_0000; ARLEN = 8'd7;
    step();
    ARVALID = 1'b0; RREADY = 1'b1;
    chk("rr_beat1_rvalid", RVALID, 1);
    step();
    chk("rr_beat2_rvalid", RVALID, 1); chk("rr_beat2_rlast", RLAST, 0);
    rst = 1'b1;
    #1;
    chk("rr_rvalid_now", RVALID, 0); chk("rr_arready_now", ARREADY, 1);
    chk("rr_err_count", err_count, 0); chk("rr_err_valid", err_valid, 0);
    step();
    rst = 1'b0;
    ARVALID = 1'b1; ARID = 8'h44; ARADDR = 32'h8000_0000; ARLEN = 8'd1;
    step();
    ARVALID = 1'b0;
    chk("post_rvalid0", RVALID, 1); chk("post_rid", RID, 8'h44); chk("post_rlast0", RLAST, 0);
    step();
    chk("post_rvalid1", RVALID, 1); chk("post_rlast1", RLAST, 1);
    step();
    chk("post_arready", ARREADY, 1); chk("post_rvalid_done", RVALID, 0);
    chk("post_err_count", err_count, 1); chk("post_err_addr", err_addr, 32'h8000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
